alu_mdu: RTL and testbench



---
 rtl/alu_mdu.sv | 177 +++++++++++++++++
 tb/tb_alu_mdu.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: multi-cycle multiply/divide unit beside the EX-stage ALU.
// It retires one bit per clock. It returns the full 2*WIDTH-bit product,
// or the quotient and remainder, in the HI/LO registers.
//
// Ports:
//   clk_i    clock; all state changes on the rising edge
//   rst_i    synchronous reset, active-high
//   start_i  request an operation (accepted in IDLE or on the edge leaving DONE)
//   op_i     bit0: 0 = multiply, 1 = divide; bit1 (MDU_SIGNED_EN only): signed
//   src1_i   multiplicand / dividend
//   src2_i   multiplier / divisor
//   busy_o   high in RUN and DONE
//   done_o   one-cycle pulse; hi_o/lo_o valid
//   hi_o     product[2W-1:W] or remainder
//   lo_o     product[W-1:0] or quotient
//   div0_o   divide-by-zero flag, held until the next done_o
//
// Optional feature macro: MDU_SIGNED_EN. When it is defined, op_i is 2 bits
// wide and signed operations are supported. Each signed operation takes one
// extra correction cycle.
//
// state  | meaning
// IDLE   | waiting for start_i
// RUN    | iterating, one bit per edge; signed ops spend a last cycle on sign fix
// DONE   | result on hi_o/lo_o, done_o high for one cycle

module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
`ifdef MDU_SIGNED_EN
  input  logic [1:0]       op_i,
`else
  input  logic             op_i,
`endif
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div0_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH:0]   r_acc;     // mul: {carry, partial hi, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   r_b;       // multiplicand or divisor magnitude
  logic               r_div, r_sgn, r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_div0;

  logic               w_div, w_sgn, w_accept, w_div0, w_last, w_fix;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_mul_sum, w_div_sh, w_div_rem;
  logic               w_div_ge;
  logic [2*WIDTH:0]   w_step;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_q_fix, w_r_fix, w_res_hi, w_res_lo;

`ifdef MDU_SIGNED_EN
  assign w_div = op_i[0];
  assign w_sgn = op_i[1];
`else
  assign w_div = op_i;
  assign w_sgn = 1'b0;
`endif

  assign w_accept = start_i && (r_state == S_IDLE || r_state == S_DONE);
  assign w_div0   = w_div && (src2_i == '0);
  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(1));
  // Signed ops use the final RUN cycle for the sign correction. No iteration runs then.
  assign w_fix    = w_last && r_sgn;

  // Signed operands are reduced to magnitudes at accept.
  assign w_a_neg = w_sgn & src1_i[WIDTH-1];
  assign w_b_neg = w_sgn & src2_i[WIDTH-1];
  assign w_a_mag = w_a_neg ? -src1_i : src1_i;
  assign w_b_mag = w_b_neg ? -src2_i : src2_i;

  // One shift-add step, or one restoring-division step.
  always_comb begin
    w_mul_sum = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_b} : '0);
    w_div_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_ge  = (w_div_sh >= {1'b0, r_b});
    w_div_rem = w_div_ge ? (w_div_sh - {1'b0, r_b}) : w_div_sh;
    if (r_div) w_step = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};
    else       w_step = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};
  end

  always_comb begin
    w_prod_fix = r_neg_q ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
    w_q_fix    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_r_fix    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    if (r_sgn) begin
      if (r_div) {w_res_hi, w_res_lo} = {w_r_fix, w_q_fix};
      else       {w_res_hi, w_res_lo} = w_prod_fix;
    end else begin
      {w_res_hi, w_res_lo} = w_step[2*WIDTH-1:0];
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) w_next = w_div0 ? S_DONE : S_RUN;
        else         w_next = S_IDLE;
      end
      S_RUN:   if (r_cnt == CNT_W'(1)) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = (r_state != S_IDLE);
    done_o = (r_state == S_DONE);
  end

  // Datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_b     <= '0;
      r_div   <= 1'b0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div0  <= 1'b0;
    end else if (w_accept) begin
      r_div   <= w_div;
      r_sgn   <= w_sgn;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_b     <= w_div ? w_b_mag : w_a_mag;
      r_acc   <= {{(WIDTH+1){1'b0}}, (w_div ? w_a_mag : w_b_mag)};
      if (w_div0) begin
        r_cnt  <= '0;
        r_hi   <= src1_i;
        r_lo   <= '1;
        r_div0 <= 1'b1;
      end else begin
        r_cnt  <= w_sgn ? CNT_W'(WIDTH + 1) : CNT_W'(WIDTH);
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (!w_fix) r_acc <= w_step;
      if (w_last) begin
        r_hi   <= w_res_hi;
        r_lo   <= w_res_lo;
        r_div0 <= 1'b0;
      end
    end
  end

  assign hi_o   = r_hi;
  assign lo_o   = r_lo;
  assign div0_o = r_div0;

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
`ifdef MDU_SIGNED_EN
  logic [1:0]  op_s = 2'b00;
`else
  logic        op_s = 1'b0;
`endif
  logic [31:0] s1 = '0, s2 = '0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  bit hold_start = 1'b0;

  always #5 clk = ~clk;

  alu_mdu dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op_s),
    .src1_i(s1), .src2_i(s2), .busy_o(busy), .done_o(done),
    .hi_o(hi), .lo_o(lo), .div0_o(div0)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        d0;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_op(input logic [1:0] op);
`ifdef MDU_SIGNED_EN
    op_s = op;
`else
    op_s = op[0];
`endif
  endtask

  // Reference: results straight from arithmetic. lat is the index of the
  // edge after the accept edge that enters DONE.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] ehi, output logic [31:0] elo,
                                output logic ed0, output int elat);
    logic [63:0] p;
    longint sa, sb;
    ed0 = 1'b0;
    if (op[0] && b == 0) begin
      ehi = a; elo = 32'hFFFF_FFFF; ed0 = 1'b1; elat = 0;
    end else if (!op[1]) begin
      elat = 32;
      if (op[0]) begin elo = a / b; ehi = a % b; end
      else begin p = 64'(a) * 64'(b); ehi = p[63:32]; elo = p[31:0]; end
    end else begin
      elat = 33;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op[0]) begin elo = 32'(sa / sb); ehi = 32'(sa % sb); end
      else begin p = 64'(sa * sb); ehi = p[63:32]; elo = p[31:0]; end
    end
  endfunction

  // Sample once per cycle at the falling edge. The first sample is in the cycle
  // after the accept edge. inj >= 0 pulses a 3*3 start at that cycle.
  task automatic wait_done(input int inj, output int lat, output int bc);
    logic b_s, d_s;
    lat = -1;
    bc  = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      b_s = busy;
      d_s = done;
      if (b_s) bc++;
      if (n == inj) begin
        start = 1'b1; set_op(2'b00); s1 = 32'd3; s2 = 32'd3;
      end else if (hold_start) begin
        if (n == 0) begin s1 = 32'd4; s2 = 32'd5; end
      end else begin
        start = 1'b0; s1 = $urandom; s2 = $urandom;
      end
      if (d_s) begin lat = n; break; end
    end
  endtask

  task automatic check_result(input string nm, input int lat, input int bc, input int elat,
                              input logic [31:0] ehi, input logic [31:0] elo, input logic ed0);
    chk({nm, " latency"}, 64'(lat), 64'(elat));
    chk({nm, " busy cycles"}, 64'(bc), 64'(elat + 1));
    chk({nm, " hi"}, 64'(hi), 64'(ehi));
    chk({nm, " lo"}, 64'(lo), 64'(elo));
    chk({nm, " div0"}, 64'(div0), 64'(ed0));
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic ed0,
                        input int elat, input string nm, input int inj);
    int lat, bc;
    @(negedge clk);
    start = 1'b1; set_op(op); s1 = a; s2 = b;
    wait_done(inj, lat, bc);
    check_result(nm, lat, bc, elat, ehi, elo, ed0);
    @(negedge clk);
    chk({nm, " idle after done"}, 64'(busy), 64'd0);
  endtask

  task automatic add(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] h, input logic [31:0] l, input logic d0, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = h; v.lo = l; v.d0 = d0; v.lat = lat;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, pulses;
    logic [1:0] op;
    logic [31:0] a, b, ehi, elo;
    logic ed0;
    int elat;

    add(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32);
    add(2'b01, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 32);
    add(2'b01, 32'h8000_0000, 32'd1,         32'd0,         32'h8000_0000, 1'b0, 32);
    add(2'b01, 32'd1234,      32'd0,         32'd1234,      32'hFFFF_FFFF, 1'b1, 0);
    add(2'b00, 32'd6,         32'd7,         32'd0,         32'd42,        1'b0, 32);
    add(2'b01, 32'd7,         32'd100,       32'd7,         32'd0,         1'b0, 32);
    add(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, 32);
    add(2'b01, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 1'b0, 32);
    add(2'b00, 32'd0,         32'd12345,     32'd0,         32'd0,         1'b0, 32);
`ifdef MDU_SIGNED_EN
    add(2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    add(2'b10, 32'hFFFF_FFFD, 32'd4,         32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0, 33);
    add(2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0);
`endif
    add(2'b00, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780, 1'b0, 32);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div0", 64'(div0), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].d0,
             vecs[i].lat, $sformatf("vec%0d", i), -1);

    // Reset on the 10th RUN cycle discards the operation and clears HI/LO.
    @(negedge clk);
    start = 1'b1; set_op(2'b00); s1 = 32'hDEAD; s2 = 32'hBEEF;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (n == 9) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst hi", 64'(hi), 64'd0);
    chk("midrst lo", 64'(lo), 64'd0);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("midrst done pulses", 64'(pulses), 64'd0);

    // A start while busy is ignored: only 25 appears, and no second result follows.
    run_op(2'b00, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0, 32, "ignore", 4);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("ignore no second op", 64'(pulses), 64'd0);

    // start_i held through DONE: accepted on the edge that leaves DONE.
    hold_start = 1'b1;
    @(negedge clk);
    start = 1'b1; set_op(2'b00); s1 = 32'd2; s2 = 32'd3;
    wait_done(-1, lat, bc);
    check_result("b2b first", lat, bc, 32, 32'd0, 32'd6, 1'b0);
    hold_start = 1'b0;
    wait_done(-1, lat, bc);
    check_result("b2b second", lat, bc, 32, 32'd0, 32'd20, 1'b0);
    @(negedge clk);
    chk("b2b idle", 64'(busy), 64'd0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      op[0] = 1'($urandom_range(0, 1));
`ifdef MDU_SIGNED_EN
      op[1] = 1'($urandom_range(0, 1));
`else
      op[1] = 1'b0;
`endif
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      model(op, a, b, ehi, elo, ed0, elat);
      run_op(op, a, b, ehi, elo, ed0, elat, $sformatf("rnd%0d", i), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
